// File: rtl/z88_pkg.sv
// Shared definitions for the Z88 LCD-to-VGA path: VGA timing, colours,
// VRAM address layout (shared with the LCD scanner) and small helpers.
package z88_pkg;

    // 640x480@60 timing, in pixels and lines
    localparam int H_ACT = 640;
    localparam int H_FP  = 16;
    localparam int H_SY  = 96;
    localparam int H_BP  = 48;
    localparam int V_ACT = 480;
    localparam int V_FP  = 10;
    localparam int V_SY  = 2;
    localparam int V_BP  = 33;

    // LCD window placement on the VGA raster
    localparam int LCD_Y0   = 112;
    localparam int LINE_REP = 4;     // VGA lines per LCD row, power of two
    localparam int LCD_ROWS = 64;
    localparam int ROW_OFF  = 16;    // writer stores LCD row 0 at VRAM row 16

    // VRAM address = {col, row}
    localparam int COL_W  = 9;
    localparam int ROW_W  = 6;
    localparam int ADDR_W = COL_W + ROW_W;

    typedef logic [11:0] color_t;

    localparam color_t COL_OFF    = 12'hBCB;
    localparam color_t COL_ON     = 12'h223;
    localparam color_t COL_GRAY   = 12'h778;
    localparam color_t COL_BORDER = 12'h000;

    // One pixel slot's worth of video control, carried down the output pipeline
    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic win;
        logic odd;
    } vid_stage_t;

    localparam vid_stage_t STAGE_IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, win: 1'b0, odd: 1'b0};

    // VRAM row for a VGA line inside the window; wraps naturally mod 64
    function automatic logic [ROW_W-1:0] vram_row(input logic [9:0] vcnt);
        logic [9:0] rel;
        logic [9:0] lcd_row;
        rel     = vcnt - 10'(LCD_Y0);
        lcd_row = rel / 10'(LINE_REP);
        return lcd_row[ROW_W-1:0] + ROW_W'(ROW_OFF);
    endfunction

    // Map one LCD pixel bit plus gray attribute to a colour
    function automatic color_t pix_color(input logic lit, input logic gray);
        color_t c;
        c = COL_OFF;
        if (lit) begin
            c = gray ? COL_GRAY : COL_ON;
        end
        return c;
    endfunction

endpackage

// File: rtl/z88_vga_timing.sv
// VGA raster generator: 25 MHz pixel enable, h/v counters, raw syncs and
// active-video flag, plus the once-per-frame toggle for the LCD scanner.
module z88_vga_timing
    import z88_pkg::*;
#(
    parameter int H_ACTIVE = H_ACT,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC   = H_SY,
    parameter int H_BACK   = H_BP
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pix_ena,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hs,
    output logic       vs,
    output logic       de,
    output logic       new_fr_tgl
);

    localparam int H_TOT = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;

    // Pixel enable, raster counters and frame toggle (toggle at start of vertical blanking)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_ena    <= 1'b0;
            hcnt       <= '0;
            vcnt       <= '0;
            new_fr_tgl <= 1'b0;
        end else begin
            pix_ena <= ~pix_ena;
            if (pix_ena) begin
                if (hcnt == 10'(H_TOT - 1)) begin
                    hcnt <= '0;
                    if (vcnt == 10'(V_TOT - 1)) begin
                        vcnt <= '0;
                    end else begin
                        vcnt <= vcnt + 10'd1;
                    end
                    if (vcnt == 10'(V_ACT - 1)) begin
                        new_fr_tgl <= ~new_fr_tgl;
                    end
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
            end
        end
    end

    // Raw (undelayed) active-low syncs and active-video flag
    always_comb begin
        hs = !((hcnt >= 10'(H_ACTIVE + H_FRONT)) && (hcnt < 10'(H_ACTIVE + H_FRONT + H_SYNC)));
        vs = !((vcnt >= 10'(V_ACT + V_FP)) && (vcnt < 10'(V_ACT + V_FP + V_SY)));
        de = (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACT));
    end

endmodule

// File: rtl/z88_vga_out.sv
// Display-side VRAM reader: fetches pixel-pair words inside the LCD window
// and produces registered RGB/syncs two pixel slots behind the counters.
module z88_vga_out
    import z88_pkg::*;
#(
    parameter int H_ACTIVE = H_ACT,
    parameter int H_FRONT  = H_FP,
    parameter int H_SYNC   = H_SY,
    parameter int H_BACK   = H_BP
) (
    input  logic              clk,
    input  logic              rst,
    output logic              new_fr_tgl,
    output logic [ADDR_W-1:0] vram_addr,
    input  logic [2:0]        vram_data,
    output logic [3:0]        vga_r,
    output logic [3:0]        vga_g,
    output logic [3:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de
);

    logic       pix_ena;
    logic [9:0] hcnt;
    logic [9:0] vcnt;
    logic       hs_raw;
    logic       vs_raw;
    logic       de_raw;
    logic       in_win;
    logic       fetch;
    logic [2:0] pair_q;
    vid_stage_t s1_reg;
    color_t     color_reg;

    z88_vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK)
    ) u_timing (
        .clk        (clk),
        .rst        (rst),
        .pix_ena    (pix_ena),
        .hcnt       (hcnt),
        .vcnt       (vcnt),
        .hs         (hs_raw),
        .vs         (vs_raw),
        .de         (de_raw),
        .new_fr_tgl (new_fr_tgl)
    );

    // LCD window: 256 VGA lines starting at LCD_Y0, all active columns
    always_comb begin
        in_win = (vcnt >= 10'(LCD_Y0)) &&
                 (vcnt < 10'(LCD_Y0 + LCD_ROWS * LINE_REP)) &&
                 (hcnt < 10'(H_ACTIVE));
        fetch  = pix_ena && in_win && !hcnt[0];
    end

    // VRAM address: one fetch per pixel pair, held outside the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vram_addr <= '0;
        end else if (fetch) begin
            vram_addr <= {hcnt[COL_W:1], vram_row(vcnt)};
        end
    end

    // Stage 1: capture the raster state of the current pixel slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_reg <= STAGE_IDLE;
        end else if (pix_ena) begin
            s1_reg <= '{hs: hs_raw, vs: vs_raw, de: de_raw, win: in_win, odd: hcnt[0]};
        end
    end

    // Hold the returned word for the odd pixel; it arrives on the even pixel's output slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_q <= '0;
        end else if (pix_ena && s1_reg.win && !s1_reg.odd) begin
            pair_q <= vram_data;
        end
    end

    // Stage 2: registered outputs; even pixel uses the word straight off the RAM port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vga_hs    <= 1'b1;
            vga_vs    <= 1'b1;
            vga_de    <= 1'b0;
            color_reg <= '0;
        end else if (pix_ena) begin
            vga_hs <= s1_reg.hs;
            vga_vs <= s1_reg.vs;
            vga_de <= s1_reg.de;
            if (!s1_reg.de) begin
                color_reg <= '0;
            end else if (!s1_reg.win) begin
                color_reg <= COL_BORDER;
            end else if (!s1_reg.odd) begin
                color_reg <= pix_color(vram_data[1], vram_data[2]);
            end else begin
                color_reg <= pix_color(pair_q[0], pair_q[2]);
            end
        end
    end

    assign vga_r = color_reg[11:8];
    assign vga_g = color_reg[7:4];
    assign vga_b = color_reg[3:0];

endmodule
